// File: rtl/seq_shift_add_mult.sv
// Sequential shift-add multiplier: one multiplier bit per RUN cycle, WIDTH RUN cycles per product.
// Optional signed mode is compiled in with the SIGNED_MULT_EN macro (adds the sgn_i port).
module seq_shift_add_mult #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
`ifdef SIGNED_MULT_EN
  input  logic                 sgn_i,
`endif
  output logic                 busy_o,
  output logic                 done_o,
  output logic [2*WIDTH-1:0]   product_o
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic [CntW-1:0]      cnt_q, cnt_d;

`ifdef SIGNED_MULT_EN
  logic sgn_q, sgn_d;
`else
  logic sgn_q;
  assign sgn_q = 1'b0;
`endif

  logic               last_step;
  logic [WIDTH:0]     upper_ext, a_ext, sum;
  logic [2*WIDTH-1:0] step_acc;

  // The multiplier lives in the low half of the accumulator: each shift consumes one
  // multiplier bit at acc[0] and frees room for one product bit at the top of the low half.
  always_comb begin
    last_step = (cnt_q == CntW'(WIDTH - 1));
    upper_ext = {sgn_q & acc_q[2*WIDTH-1], acc_q[2*WIDTH-1:WIDTH]};
    a_ext     = {sgn_q & a_q[WIDTH-1], a_q};
    sum       = upper_ext;
    if (acc_q[0]) begin
      // In two's complement the multiplier MSB carries weight -2^(WIDTH-1).
      if (sgn_q && last_step) sum = upper_ext - a_ext;
      else                    sum = upper_ext + a_ext;
    end
    step_acc  = {sum, acc_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    acc_d   = acc_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;
`ifdef SIGNED_MULT_EN
    sgn_d   = sgn_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StRun;
          a_d     = a_i;
          acc_d   = {{WIDTH{1'b0}}, b_i};
          cnt_d   = '0;
`ifdef SIGNED_MULT_EN
          sgn_d   = sgn_i;
`endif
        end
      end
      StRun: begin
        acc_d = step_acc;
        cnt_d = cnt_q + CntW'(1);
        if (last_step) begin
          state_d = StDone;
          prod_d  = step_acc;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      a_q     <= '0;
      acc_q   <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      acc_q   <= acc_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef SIGNED_MULT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) sgn_q <= 1'b0;
    else       sgn_q <= sgn_d;
  end
`endif

  assign busy_o    = (state_q != StIdle);
  assign done_o    = (state_q == StDone);
  assign product_o = prod_q;

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Bench for seq_shift_add_mult: WIDTH=8 directed cases plus a WIDTH=4 exhaustive sweep,
// checked every cycle against a timeline/arithmetic model and against literal expectations.
module tb_seq_shift_add_mult;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        sgn8 = 1'b0;
  logic        busy8, done8;
  logic [15:0] product8;

  logic        start4 = 1'b0;
  logic [3:0]  a4 = '0, b4 = '0;
  logic        busy4, done4;
  logic [7:0]  product4;

  seq_shift_add_mult #(.WIDTH(8)) u_dut8 (
    .clk_i     (clk),
    .rst_i     (rst),
    .start_i   (start8),
    .a_i       (a8),
    .b_i       (b8),
`ifdef SIGNED_MULT_EN
    .sgn_i     (sgn8),
`endif
    .busy_o    (busy8),
    .done_o    (done8),
    .product_o (product8)
  );

  seq_shift_add_mult #(.WIDTH(4)) u_dut4 (
    .clk_i     (clk),
    .rst_i     (rst),
    .start_i   (start4),
    .a_i       (a4),
    .b_i       (b4),
`ifdef SIGNED_MULT_EN
    .sgn_i     (1'b0),
`endif
    .busy_o    (busy4),
    .done_o    (done4),
    .product_o (product4)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  int d8_cnt = 0;
  int d4_cnt = 0;

  task automatic check(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", nm, act, act, exp, exp,
               $time);
    end
  endtask

  function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic s);
    logic signed [15:0] sa, sb;
    if (s) begin
      sa = $signed({{8{a[7]}}, a});
      sb = $signed({{8{b[7]}}, b});
      return 16'(sa * sb);
    end
    return 16'({8'd0, a} * {8'd0, b});
  endfunction

  // Timeline model: an accepted start means WIDTH RUN cycles then one DONE cycle;
  // m*_left counts the busy cycles still to come including the current one.
  int          m8_left = 0, m4_left = 0;
  logic [15:0] m8_prod = '0, m8_pend = '0;
  logic [7:0]  m4_prod = '0, m4_pend = '0;

  always @(posedge clk) begin
    if (rst) begin
      m8_left = 0; m8_prod = '0;
      m4_left = 0; m4_prod = '0;
    end else begin
      if (m8_left == 0) begin
        if (start8) begin
          m8_left = 9;
          m8_pend = ref8(a8, b8, sgn8);
        end
      end else begin
        m8_left--;
        if (m8_left == 1) m8_prod = m8_pend;
      end
      if (m4_left == 0) begin
        if (start4) begin
          m4_left = 5;
          m4_pend = {4'd0, a4} * {4'd0, b4};
        end
      end else begin
        m4_left--;
        if (m4_left == 1) m4_prod = m4_pend;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy8", busy8, m8_left > 0);
      check("done8", done8, m8_left == 1);
      check("product8", product8, m8_prod);
      check("busy4", busy4, m4_left > 0);
      check("done4", done4, m4_left == 1);
      check("product4", product4, m4_prod);
      if (done8) d8_cnt++;
      if (done4) d4_cnt++;
    end
  end

  // Launch one WIDTH=8 operation from IDLE, wait for done, check result and latency.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s,
                     input logic [15:0] exp, input string nm);
    int n;
    a8 = a; b8 = b; sgn8 = s; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    n = 1;
    while (!done8 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({nm, " product"}, product8, exp);
    check({nm, " latency"}, n, 9);
    @(negedge clk);
  endtask

  initial begin
    int n, base;
    @(negedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    check("reset busy", busy8, 0);
    check("reset done", done8, 0);
    check("reset product", product8, 0);
    rst = 1'b0;
    @(negedge clk);

    op8(8'd13, 8'd11, 1'b0, 16'd143, "13x11");
    repeat (3) @(negedge clk);
    check("13x11 hold", product8, 143);

    op8(8'd255, 8'd255, 1'b0, 16'hFE01, "255x255");
    op8(8'd0, 8'd200, 1'b0, 16'd0, "0x200");
    op8(8'd253, 8'd5, 1'b0, 16'd1265, "253x5 unsigned");

    // Restart attempt mid-RUN with changing operands must be ignored.
    base = d8_cnt;
    a8 = 8'd13; b8 = 8'd11; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (2) @(negedge clk);
    a8 = 8'd1; b8 = 8'd1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0; a8 = 8'd77; b8 = 8'd99;
    n = 4;
    while (!done8 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ignored start product", product8, 143);
    check("ignored start latency", n, 9);
    repeat (12) @(negedge clk);
    check("ignored start done count", d8_cnt - base, 1);

    // Reset 4 cycles into RUN aborts without a done pulse.
    base = d8_cnt;
    a8 = 8'd13; b8 = 8'd11; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort busy", busy8, 0);
    check("abort done", done8, 0);
    check("abort product", product8, 0);
    repeat (12) @(negedge clk);
    check("abort done count", d8_cnt - base, 0);
    op8(8'd7, 8'd6, 1'b0, 16'd42, "7x6 after reset");

`ifdef SIGNED_MULT_EN
    op8(8'hFD, 8'd5, 1'b1, 16'hFFF1, "signed -3x5");
    op8(8'h80, 8'h80, 1'b1, 16'h4000, "signed -128x-128");
    op8(8'h7F, 8'h80, 1'b1, 16'hC080, "signed 127x-128");
    op8(8'hFD, 8'd5, 1'b0, 16'd1265, "sgn0 253x5");
`endif

    // WIDTH=4 sweep with start held high: operands for the next op are set during DONE.
    base = d4_cnt;
    a4 = 4'd0; b4 = 4'd0; start4 = 1'b1;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      n = 1;
      while (!done4 && n < 20) begin
        @(negedge clk);
        n++;
      end
      check("sweep4 product", product4, (i >> 4) * (i & 15));
      check("sweep4 spacing", n, (i == 0) ? 5 : 6);
      if (i < 255) begin
        a4 = 4'((i + 1) >> 4);
        b4 = 4'((i + 1) & 15);
      end else begin
        start4 = 1'b0;
      end
    end
    repeat (3) @(negedge clk);
    check("sweep4 done count", d4_cnt - base, 256);
    check("sweep4 last literal", product4, 225);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
